// File: rtl/bfm_ahbapb_pkg.sv
// Shared types and helpers for the parametrised AHB-Lite to APB bridge.
// Strobe/protection helpers are only consumed when BFM_AHBTOAPB_APB4_EN is set.
package bfm_ahbapb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;

  function automatic logic [3:0] strb_gen(
    input logic       write,
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic [3:0] s;
    s = 4'h0;
    if (write) begin
      case (size)
        HSIZE_BYTE: s = 4'b0001 << a;
        HSIZE_HALF: s = 4'b0011 << {a[1], 1'b0};
        default:    s = 4'hF;
      endcase
    end
    return s;
  endfunction

  // AHB HPROT[0]=data, [1]=privileged; APB PPROT[2]=instr, [0]=privileged
  function automatic logic [2:0] pprot_map(
    input logic [1:0] hprot
  );
    return {~hprot[0], 1'b1, hprot[1]};
  endfunction

endpackage

// File: rtl/bfm_ahbapb_tocnt.sv
// PREADY timeout counter for the bridge ACCESS phase.
// Counts low-PREADY cycles; expire flags the terminal cycle.
module bfm_ahbapb_tocnt #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    logic unused;
    assign unused = ^{clk, rst, en, clr};
    assign expire = 1'b0;
  end else begin : g_on
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign expire = en & (cnt == LAST);
  end

endmodule

// File: rtl/bfm_ahbtoapb_gen.sv
// Parametrised AHB-Lite slave to APB master bridge with error/timeout abort.
// Define BFM_AHBTOAPB_APB4_EN to add the APB4 PSTRB/PPROT outputs.
module bfm_ahbtoapb_gen
  import bfm_ahbapb_pkg::*;
#(
  parameter int NUM_SLAVES = 16,
  parameter int SEL_LSB    = 24,
  parameter int SEL_BITS   = 4,
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 0,
  parameter int TPD        = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_W-1:0]     HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HREADYIN,
  input  logic                  HMASTLOCK,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic [ADDR_W-1:0]     PADDR,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  TOUT
`ifdef BFM_AHBTOAPB_APB4_EN
  ,
  output logic [3:0]            PSTRB,
  output logic [2:0]            PPROT
`endif
);

  state_t state;
  state_t nxt;

  logic [ADDR_W-1:0]     addr_q;
  logic                  write_q;
  logic [SEL_BITS-1:0]   idx_q;
  logic [31:0]           wdata_q;
  logic                  tout_q;
  logic [SEL_BITS-1:0]   idx;
  logic [31:0]           idx_ext;
  logic [NUM_SLAVES-1:0] sel_hot;
  logic                  accept;
  logic                  mapped;
  logic                  done;
  logic                  take;
  logic                  expire;
  logic                  in_access;

  assign accept    = HSEL & HREADYIN & HTRANS[1];
  assign idx       = HADDR[SEL_LSB +: SEL_BITS];
  assign idx_ext   = 32'(idx);
  assign mapped    = idx_ext < 32'(NUM_SLAVES);
  assign in_access = (state == ST_ACCESS);
  assign done      = in_access & PREADY & ~PSLVERR;
  assign take      = accept & ((state == ST_IDLE) |
                               (state == ST_ERR2) | done);
  assign sel_hot   = NUM_SLAVES'(1) << idx_q;

  bfm_ahbapb_tocnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tocnt (
    .clk    (HCLK),
    .rst    (HRESET),
    .en     (in_access & ~PREADY),
    .clr    (~in_access),
    .expire (expire)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (accept) begin
          nxt = mapped ? ST_SETUP : ST_ERR1;
        end else begin
          nxt = ST_IDLE;
        end
      end
      ST_SETUP: nxt = ST_ACCESS;
      ST_ACCESS: begin
        // PREADY takes priority over a coincident timeout
        if (PREADY) begin
          if (PSLVERR) begin
            nxt = ST_ERR1;
          end else if (accept) begin
            nxt = mapped ? ST_SETUP : ST_ERR1;
          end else begin
            nxt = ST_IDLE;
          end
        end else if (expire) begin
          nxt = ST_ERR1;
        end
      end
      ST_ERR1: nxt = ST_ERR2;
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    PSEL      = '0;
    PENABLE   = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    PWDATA    = wdata_q;
    HRDATA    = '0;
    case (state)
      ST_SETUP: begin
        PSEL      = sel_hot;
        HREADYOUT = 1'b0;
        PWDATA    = HWDATA;
      end
      ST_ACCESS: begin
        PSEL      = sel_hot;
        PENABLE   = 1'b1;
        HREADYOUT = PREADY & ~PSLVERR;
        HRDATA    = PRDATA;
      end
      ST_ERR1: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b0;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      tout_q <= in_access & ~PREADY & expire;
      if (state == ST_SETUP) begin
        wdata_q <= HWDATA;
      end
      if (take) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        idx_q   <= idx;
      end
    end
  end

  assign PADDR  = addr_q;
  assign PWRITE = write_q;
  assign TOUT   = tout_q;

`ifdef BFM_AHBTOAPB_APB4_EN
  logic [3:0] strb_q;
  logic [2:0] prot_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      strb_q <= '0;
      prot_q <= '0;
    end else if (take) begin
      strb_q <= strb_gen(HWRITE, HSIZE, HADDR[1:0]);
      prot_q <= pprot_map(HPROT[1:0]);
    end
  end

  assign PSTRB = strb_q;
  assign PPROT = prot_q;

  logic unused;
  assign unused = ^{HMASTLOCK, HBURST, HTRANS[0],
                    HPROT[3:2], 32'(TPD)};
`else
  logic unused;
  assign unused = ^{HMASTLOCK, HBURST, HTRANS[0],
                    HSIZE, HPROT, 32'(TPD)};
`endif

endmodule
